// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the two-port data memory arbiter.
// slave : arbiter view (requests and mem_rdata in; responses and memory controls out)
// master: environment view (requesters plus data memory), the mirror image of slave
interface dmem_arbiter_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 20
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [WIDTH-1:0]  wdata0;
  logic [WIDTH-1:0]  wdata1;
  logic [2:0]        funct3_0;
  logic [2:0]        funct3_1;
  logic              resp_valid0;
  logic              resp_valid1;
  logic              resp_err0;
  logic              resp_err1;
  logic [WIDTH-1:0]  rdata0;
  logic [WIDTH-1:0]  rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_wr;
  logic              mem_rd;
  logic              mem_one_byte;
  logic              mem_two_byte;
  logic              mem_four_bytes;
  logic [WIDTH-1:0]  mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, funct3_0, funct3_1,
    output resp_valid0, resp_valid1, resp_err0, resp_err1, rdata0, rdata1,
    output mem_addr, mem_wdata, mem_wr, mem_rd, mem_one_byte, mem_two_byte, mem_four_bytes,
    input  mem_rdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, funct3_0, funct3_1,
    input  resp_valid0, resp_valid1, resp_err0, resp_err1, rdata0, rdata1,
    input  mem_addr, mem_wdata, mem_wr, mem_rd, mem_one_byte, mem_two_byte, mem_four_bytes,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the byte-addressed data memory.
// Ports: clk, rst (synchronous, active-high), bus (dmem_arbiter_if.slave):
//   req/we/addr/wdata/funct3 per port in, resp_valid/resp_err/rdata per port out,
//   mem_addr/mem_wdata/mem_wr/mem_rd/size selects out, mem_rdata in.
// One access in flight; every output is a register.
module dmem_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 20
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [1:0]        resp_err_q, resp_err_d;
  logic [WIDTH-1:0]  rdata0_q, rdata0_d;
  logic [WIDTH-1:0]  rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              one_q, one_d;
  logic              two_q, two_d;
  logic              four_q, four_d;

  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_wdata;
  logic [2:0]        sel_f3;

  // Size/alignment legality of a request
  function automatic logic is_legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b100:  ok = !we;
      3'b001:  ok = !a[0];
      3'b101:  ok = !we && !a[0];
      3'b010:  ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Load data extension; memory returns the addressed unit in the low bits
  function automatic logic [WIDTH-1:0] extend(input logic [2:0] f3, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    case (f3)
      3'b000:  r = {{(WIDTH-8){d[7]}}, d[7:0]};
      3'b100:  r = {{(WIDTH-8){1'b0}}, d[7:0]};
      3'b001:  r = {{(WIDTH-16){d[15]}}, d[15:0]};
      3'b101:  r = {{(WIDTH-16){1'b0}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Grant: pointer breaks ties, otherwise whichever port is requesting
  always_comb begin
    sel_port  = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
    sel_we    = sel_port ? bus.we1      : bus.we0;
    sel_addr  = sel_port ? bus.addr1    : bus.addr0;
    sel_wdata = sel_port ? bus.wdata1   : bus.wdata0;
    sel_f3    = sel_port ? bus.funct3_1 : bus.funct3_0;
  end

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    port_d       = port_q;
    we_d         = we_q;
    f3_d         = f3_q;
    resp_valid_d = 2'b00;
    resp_err_d   = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wr_d     = 1'b0;
    mem_rd_d     = 1'b0;
    one_d        = 1'b0;
    two_d        = 1'b0;
    four_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          port_d = sel_port;
          we_d   = sel_we;
          f3_d   = sel_f3;
          if (is_legal(sel_we, sel_f3, sel_addr[1:0])) begin
            state_d     = ISSUE;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_wr_d    = sel_we;
            mem_rd_d    = !sel_we;
            one_d       = (sel_f3[1:0] == 2'b00);
            two_d       = (sel_f3[1:0] == 2'b01);
            four_d      = (sel_f3[1:0] == 2'b10);
          end else begin
            // Rejected without touching memory
            state_d                = RESP;
            resp_valid_d[sel_port] = 1'b1;
            resp_err_d[sel_port]   = 1'b1;
            if (sel_port) rdata1_d = '0;
            else          rdata0_d = '0;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d              = RESP;
          resp_valid_d[port_q] = 1'b1;
          if (port_q) rdata1_d = '0;
          else        rdata0_d = '0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d              = RESP;
        resp_valid_d[port_q] = 1'b1;
        if (port_q) rdata1_d = extend(f3_q, bus.mem_rdata);
        else        rdata0_d = extend(f3_q, bus.mem_rdata);
      end
      RESP: begin
        ptr_d   = !port_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      resp_valid_q <= 2'b00;
      resp_err_q   <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      one_q        <= 1'b0;
      two_q        <= 1'b0;
      four_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      port_q       <= port_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_q     <= mem_wr_d;
      mem_rd_q     <= mem_rd_d;
      one_q        <= one_d;
      two_q        <= two_d;
      four_q       <= four_d;
    end
  end

  assign bus.resp_valid0    = resp_valid_q[0];
  assign bus.resp_valid1    = resp_valid_q[1];
  assign bus.resp_err0      = resp_err_q[0];
  assign bus.resp_err1      = resp_err_q[1];
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wr         = mem_wr_q;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.mem_one_byte   = one_q;
  assign bus.mem_two_byte   = two_q;
  assign bus.mem_four_bytes = four_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected responses, a
// negedge monitor checks memory strobes and pops/compares each response.
module tb_dmem_arbiter;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 20;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   strobes = 0;
  int   resp_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  dmem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Byte memory with registered read data; read returns the 4 bytes from addr upward
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else begin
      if (bus.mem_wr) begin
        mem[bus.mem_addr[9:0]] <= bus.mem_wdata[7:0];
        if (bus.mem_two_byte || bus.mem_four_bytes)
          mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_wdata[15:8];
        if (bus.mem_four_bytes) begin
          mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_wdata[23:16];
          mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_wdata[31:24];
        end
      end
      if (bus.mem_rd)
        bus.mem_rdata <= {mem[bus.mem_addr[9:0] + 10'd3], mem[bus.mem_addr[9:0] + 10'd2],
                          mem[bus.mem_addr[9:0] + 10'd1], mem[bus.mem_addr[9:0]]};
    end
  end

  typedef struct {
    bit              port;
    bit              we;
    bit [2:0]        f3;
    bit [ADDR_W-1:0] addr;
    bit [WIDTH-1:0]  wdata;
    bit              err;
    bit [WIDTH-1:0]  rdata;
    int              start;
    int              lat;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobes checked against the in-flight entry, responses popped in order
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        strobes = 0;
      end else begin
        if (bus.mem_wr || bus.mem_rd) begin
          strobes++;
          if (q.size() > 0) begin
            e = q[0];
            check("strobe_ctl", {bus.mem_wr, bus.mem_rd, bus.mem_one_byte, bus.mem_two_byte, bus.mem_four_bytes},
                  {e.we, !e.we, (e.f3[1:0] == 2'b00), (e.f3[1:0] == 2'b01), (e.f3[1:0] == 2'b10)});
            check("strobe_addr", bus.mem_addr, e.addr);
            if (e.we) check("strobe_wdata", bus.mem_wdata, e.wdata);
          end
        end
        if (bus.resp_valid0 || bus.resp_valid1) begin
          resp_count++;
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: actual valid0=%0b valid1=%0b, required none (cycle %0d)",
                     bus.resp_valid0, bus.resp_valid1, cyc);
          end else begin
            e = q.pop_front();
            check("resp_port", {bus.resp_valid1, bus.resp_valid0}, e.port ? 2'b10 : 2'b01);
            check("resp_err", e.port ? bus.resp_err1 : bus.resp_err0, e.err);
            check("resp_rdata", e.port ? bus.rdata1 : bus.rdata0, e.rdata);
            if (e.lat >= 0) check("resp_latency", cyc - e.start, e.lat);
            check("strobe_count", strobes, e.err ? 0 : 1);
            strobes = 0;
          end
        end
      end
    end
  end

  task automatic push(input bit port, input bit we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                      input logic [WIDTH-1:0] wdata, input bit err, input logic [WIDTH-1:0] rdata, input int lat);
    exp_t e;
    e.port = port; e.we = we; e.f3 = f3; e.addr = addr; e.wdata = wdata;
    e.err = err; e.rdata = rdata; e.start = cyc; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic drive(input bit port, input bit we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                       input logic [WIDTH-1:0] wdata);
    if (port) begin
      bus.we1 = we; bus.funct3_1 = f3; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end else begin
      bus.we0 = we; bus.funct3_0 = f3; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end
  endtask

  // Wait for this port's response, optionally scrambling its inputs once latched, then drop req
  task automatic wait_resp(input bit port, input bit scramble);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (port ? bus.resp_valid1 : bus.resp_valid0) done = 1'b1;
      else if (scramble && i == 1) begin
        if (port) begin
          bus.addr1 = bus.addr1 ^ 20'h3F; bus.wdata1 = ~bus.wdata1;
          bus.funct3_1 = bus.funct3_1 ^ 3'b111; bus.we1 = ~bus.we1;
        end else begin
          bus.addr0 = bus.addr0 ^ 20'h3F; bus.wdata0 = ~bus.wdata0;
          bus.funct3_0 = bus.funct3_0 ^ 3'b111; bus.we0 = ~bus.we0;
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_port%0d: actual no resp_valid, required one within 40 cycles", port);
    end
    @(posedge clk); #1;
    if (port) bus.req1 = 1'b0;
    else      bus.req0 = 1'b0;
  endtask

  task automatic access(input bit port, input bit we, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                        input logic [WIDTH-1:0] wdata, input bit err, input logic [WIDTH-1:0] rdata, input int lat);
    @(posedge clk); #1;
    push(port, we, f3, addr, wdata, err, rdata, lat);
    drive(port, we, f3, addr, wdata);
    wait_resp(port, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp"}, {bus.resp_valid0, bus.resp_valid1, bus.resp_err0, bus.resp_err1}, 0);
    check({tag, "_strobes"}, {bus.mem_wr, bus.mem_rd, bus.mem_one_byte, bus.mem_two_byte, bus.mem_four_bytes}, 0);
    check({tag, "_rdata0"}, bus.rdata0, 0);
    check({tag, "_rdata1"}, bus.rdata1, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    bit ok;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.funct3_0 = 3'b000; bus.funct3_1 = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Word store/load, sub-word stores, extension
    access(0, 1, 3'b010, 20'h100, 32'hDEADBEEF, 0, 32'h0, 2);
    access(0, 0, 3'b010, 20'h100, 32'h0,        0, 32'hDEADBEEF, 3);
    access(0, 1, 3'b000, 20'h104, 32'h12345680, 0, 32'h0, 2);
    access(1, 1, 3'b001, 20'h106, 32'hAAAA8001, 0, 32'h0, 2);
    access(0, 0, 3'b000, 20'h104, 32'h0, 0, 32'hFFFFFF80, 3);
    access(1, 0, 3'b100, 20'h104, 32'h0, 0, 32'h00000080, 3);
    access(0, 0, 3'b001, 20'h106, 32'h0, 0, 32'hFFFF8001, 3);
    access(1, 0, 3'b101, 20'h106, 32'h0, 0, 32'h00008001, 3);

    // Misaligned and illegal requests
    access(0, 0, 3'b010, 20'h102, 32'h0,        1, 32'h0, 1);
    access(1, 1, 3'b001, 20'h101, 32'h5555AAAA, 1, 32'h0, 1);
    access(0, 1, 3'b100, 20'h108, 32'h000000FF, 1, 32'h0, 1);
    access(1, 0, 3'b011, 20'h108, 32'h0,        1, 32'h0, 1);

    // Leave nonzero rdata on both ports and the pointer at port 1
    access(1, 0, 3'b010, 20'h100, 32'h0, 0, 32'hDEADBEEF, 3);
    access(0, 0, 3'b000, 20'h104, 32'h0, 0, 32'hFFFFFF80, 3);

    // Reset during CAPTURE of a port 1 load: no response, everything back to reset values
    @(posedge clk); #1;
    drive(1, 0, 3'b010, 20'h100, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    bus.req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1 rst = 1'b0;

    // Simultaneous requests after reset: port 0 first
    @(posedge clk); #1;
    push(0, 0, 3'b010, 20'h100, 32'h0, 0, 32'hDEADBEEF, 3);
    push(1, 0, 3'b100, 20'h104, 32'h0, 0, 32'h00000080, 7);
    drive(0, 0, 3'b010, 20'h100, 32'h0);
    drive(1, 0, 3'b100, 20'h104, 32'h0);
    fork
      wait_resp(0, 1'b0);
      wait_resp(1, 1'b0);
    join

    // Both ports requesting continuously after reset: grants 0,1,0,1
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      push(0, 1, 3'b010, 20'h200, 32'h11112222, 0, 32'h0, -1);
      push(1, 1, 3'b010, 20'h204, 32'h3333C444, 0, 32'h0, -1);
    end
    drive(0, 1, 3'b010, 20'h200, 32'h11112222);
    drive(1, 1, 3'b010, 20'h204, 32'h3333C444);
    base = resp_count;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk); #1;
      if (resp_count >= base + 4) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL alternate_timeout: actual %0d responses, required 4", resp_count - base);
    end
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    // Read back the alternating stores
    access(0, 0, 3'b010, 20'h200, 32'h0, 0, 32'h11112222, 3);
    access(1, 0, 3'b001, 20'h204, 32'h0, 0, 32'hFFFFC444, 3);

    repeat (5) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the byte-addressed data memory. Port 0 serves the core load/store unit and port 1 serves the debug/DMA master. The block picks one request at a time round-robin and checks its size and alignment. It drives exactly one single-cycle memory strobe per legal access, then captures and sign- or zero-extends read data. It sits between the requesters and the data memory, owns all memory control inputs, and returns one response pulse per request.

## Interface
- WIDTH, 32, data width in bits
- ADDR_W, 20, byte address width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  request; held high until the matching resp_valid
- we0 / we1  in  1  1 = store, 0 = load
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  WIDTH  store data, low bytes used for sub-word stores
- funct3_0 / funct3_1  in  3  RISC-V size code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- resp_valid0 / resp_valid1  out  1  one-cycle completion pulse
- resp_err0 / resp_err1  out  1  qualified by resp_valid; illegal or misaligned access
- rdata0 / rdata1  out  WIDTH  extended load data, qualified by resp_valid
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  WIDTH  to memory
- mem_wr, mem_rd  out  1  memory strobes
- mem_one_byte, mem_two_byte, mem_four_bytes  out  1  memory size selects, one-hot during a strobe
- mem_rdata  in  WIDTH  memory read data, registered inside memory, valid the cycle after mem_rd

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE:**
  - If any req is high, choose a port.
  - If both are high, choose the port indicated by the priority pointer.
  - Latch the chosen port's we, addr, wdata and funct3, and the port index.
  - Decode the latched request:
    - legal → ISSUE
    - illegal → RESP with err set
- **Illegal requests:**
  - Store funct3 not in {000, 001, 010}.
  - Load funct3 not in {000, 001, 010, 100, 101}.
  - Halfword with addr[0] = 1.
  - Word with addr[1:0] ≠ 00.
  - An illegal request never produces a memory strobe.
- **ISSUE:**
  - Drive mem_addr and mem_wdata from the latch.
  - Assert exactly one of mem_wr or mem_rd.
  - Assert exactly one size select.
  - Store → RESP; load → CAPTURE.
- **CAPTURE:** sample mem_rdata into the response register, then go to RESP.
  - 000: sign-extend bit 7.
  - 100: zero-extend bits 7:0.
  - 001: sign-extend bit 15.
  - 101: zero-extend bits 15:0.
  - 010: pass unchanged.
- **RESP:**
  - Pulse resp_valid on the served port only.
  - resp_err and rdata are valid on that port.
  - rdata = 0 for stores and errors.
  - Toggle the priority pointer to the port not just served.
  - Go to IDLE.
- **Requester rule:** the requester drops req on the clock edge at which it samples resp_valid. A req still high in the following IDLE cycle is a new request.
- **Outside ISSUE:** mem_wr, mem_rd and all size selects are 0. mem_addr and mem_wdata hold their last value.
- **Ignored input changes:** changes to a port's inputs after latching are ignored until its response.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled.
- Load: ISSUE in cycle 1, CAPTURE in cycle 2, resp_valid in cycle 3.
- Store: ISSUE in cycle 1, resp_valid in cycle 2.
- Error: resp_valid with err in cycle 1; no memory activity.
- One access is in flight at a time. Minimum request spacing through IDLE: load 4 cycles, store 3, error 2.
- Starvation is impossible. With both ports requesting continuously, grants alternate 0, 1, 0, 1, …
- Reset values:
  - state = IDLE; priority pointer = port 0
  - all resp_valid, resp_err, mem_wr, mem_rd and size selects = 0
  - rdata0, rdata1, mem_addr, mem_wdata = 0
- Reset mid-operation:
  - Abort to IDLE the next cycle; the aborted request gets no response.
  - No strobe is asserted in the cycle after rst is sampled high.
  - Requesters re-issue after reset.

## Test plan
- Port 0 store sw at addr 0x100, wdata 0xDEADBEEF, then lw at 0x100:
  - cycle 1: mem_wr with mem_four_bytes; cycle 2: resp_valid0 = 1.
  - Load response 3 cycles after sampling, rdata0 = 0xDEADBEEF, err = 0.
- Sign extension, with memory byte 0x80 at 0x104 and halfword 0x8001 at 0x106:
  - lb 0x104 → 0xFFFFFF80; lbu 0x104 → 0x00000080.
  - lh 0x106 → 0xFFFF8001; lhu 0x106 → 0x00008001.
- Misaligned and illegal requests each give resp_err = 1 one cycle after sampling, with no mem strobe:
  - lw at 0x102; sh at 0x101; store with funct3 = 100; load with funct3 = 011.
- req0 and req1 both held continuously with stores:
  - Grant order after reset: 0, 1, 0, 1.
  - Each resp_valid appears only on the served port.
- rst asserted during CAPTURE of a port 1 load:
  - No resp_valid1.
  - All outputs at reset values the next cycle.
  - The pointer returns to 0, so a simultaneous req0 and req1 afterwards serves port 0 first.
